// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port memory between the instruction-fetch stage and the
// data (load/store) stage. One transaction is on the bus at a time. When both
// stages request together, the grant alternates so that neither stage starves.
// A wait counter aborts a bus transaction that goes unacknowledged for TIMEOUT
// cycles.
//
// Ports
//   clk, rst                       clock (rising edge); asynchronous active-high reset
//   if_req, if_addr                fetch request and word address
//   if_rdata, if_ready             fetch read data; one-cycle completion pulse
//   mem_req, mem_we, mem_addr,
//   mem_wdata, mem_be              data-stage request
//   mem_rdata, mem_ready           data-stage read data; one-cycle completion pulse
//   bus_req, bus_we, bus_addr,
//   bus_wdata, bus_be              request to the shared memory
//   bus_rdata, bus_ack             memory response (meaningful only while bus_req=1)
//   fetch_stall, mem_stall         pipeline stall lines
//   bus_err                        one-cycle pulse, with the ready pulse, on timeout
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_be,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        fetch_stall,
    output logic        mem_stall,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GRANT_IF  = 2'd1,
        GRANT_MEM = 2'd2
    } state_t;

    // Wait-counter value on the last cycle a grant may wait for its ack.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;   // 0 = fetch, 1 = data stage
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic        if_ready_q, if_ready_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;
    logic        mem_ready_q, mem_ready_d;
    logic        bus_err_q, bus_err_d;

    logic        if_pend, mem_pend;
    logic        grant_if, grant_mem;
    logic        done;
    logic [31:0] done_data;

    // A requester whose ready pulse is showing this cycle is still seeing its
    // own request high; it must not be granted again until the pulse is gone.
    assign if_pend  = if_req  & ~if_ready_q;
    assign mem_pend = mem_req & ~mem_ready_q;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        bus_we_d     = bus_we_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        bus_be_d     = bus_be_q;
        wait_cnt_d   = wait_cnt_q;
        if_rdata_d   = if_rdata_q;
        mem_rdata_d  = mem_rdata_q;
        if_ready_d   = 1'b0;
        mem_ready_d  = 1'b0;
        bus_err_d    = 1'b0;
        // On contention the data stage wins unless it was granted last.
        grant_mem    = mem_pend & (~if_pend | ~last_grant_q);
        grant_if     = if_pend & ~grant_mem;
        // A grant ends on ack or on the timeout boundary; ack takes priority.
        done         = bus_ack | (wait_cnt_q == CNT_LAST);
        done_data    = bus_ack ? bus_rdata : 32'h0;

        case (state_q)
            IDLE: begin
                if (grant_mem) begin
                    state_d      = GRANT_MEM;
                    last_grant_d = 1'b1;
                    bus_we_d     = mem_we;
                    bus_addr_d   = mem_addr;
                    bus_wdata_d  = mem_wdata;
                    bus_be_d     = mem_be;
                    wait_cnt_d   = 8'd0;
                end else if (grant_if) begin
                    state_d      = GRANT_IF;
                    last_grant_d = 1'b0;
                    bus_we_d     = 1'b0;
                    bus_addr_d   = if_addr;
                    bus_wdata_d  = 32'h0;
                    bus_be_d     = 4'hF;
                    wait_cnt_d   = 8'd0;
                end
            end
            GRANT_IF, GRANT_MEM: begin
                if (done) begin
                    state_d   = IDLE;
                    bus_err_d = ~bus_ack;
                    if (state_q == GRANT_IF) begin
                        if_ready_d = 1'b1;
                        if_rdata_d = done_data;
                    end else begin
                        mem_ready_d = 1'b1;
                        mem_rdata_d = done_data;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= 32'h0;
            bus_wdata_q  <= 32'h0;
            bus_be_q     <= 4'h0;
            wait_cnt_q   <= 8'd0;
            if_rdata_q   <= 32'h0;
            if_ready_q   <= 1'b0;
            mem_rdata_q  <= 32'h0;
            mem_ready_q  <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            bus_be_q     <= bus_be_d;
            wait_cnt_q   <= wait_cnt_d;
            if_rdata_q   <= if_rdata_d;
            if_ready_q   <= if_ready_d;
            mem_rdata_q  <= mem_rdata_d;
            mem_ready_q  <= mem_ready_d;
            bus_err_q    <= bus_err_d;
        end
    end

    assign bus_req     = (state_q != IDLE);
    assign bus_we      = bus_we_q;
    assign bus_addr    = bus_addr_q;
    assign bus_wdata   = bus_wdata_q;
    assign bus_be      = bus_be_q;
    assign if_rdata    = if_rdata_q;
    assign if_ready    = if_ready_q;
    assign mem_rdata   = mem_rdata_q;
    assign mem_ready   = mem_ready_q;
    assign bus_err     = bus_err_q;
    assign fetch_stall = if_req & ~if_ready_q;
    assign mem_stall   = mem_req & ~mem_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Self-checking bench for mem_port_arbiter. A transaction-level model (which
// requester owns the bus, how long it has waited, what each side last read)
// predicts every output; a negedge process compares the DUT with it on every
// cycle. Directed sequences pin the model with literal expectations, then a
// long randomized run exercises contention, slow/absent acks and resets.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, mem_req, mem_we, bus_ack;
    logic [31:0] if_addr, mem_addr, mem_wdata, bus_rdata;
    logic [3:0]  mem_be;
    logic [31:0] if_rdata, mem_rdata, bus_addr, bus_wdata;
    logic        if_ready, mem_ready, bus_req, bus_we;
    logic [3:0]  bus_be;
    logic        fetch_stall, mem_stall, bus_err;

    int n_checks = 0;
    int n_fail   = 0;

    mem_port_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr),
        .if_rdata(if_rdata), .if_ready(if_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_be(bus_be),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .fetch_stall(fetch_stall), .mem_stall(mem_stall), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    int          m_owner;        // 0 = nobody, 1 = fetch, 2 = data stage
    int          m_waited;       // grant cycles already spent without ack
    bit          m_last_mem;     // most recent grant went to the data stage
    logic        m_we;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_be;
    logic        m_if_rdy, m_mem_rdy, m_err;
    logic [31:0] m_if_rd, m_mem_rd;

    task automatic m_reset();
        m_owner = 0; m_waited = 0; m_last_mem = 1'b0;
        m_we = 1'b0; m_addr = 32'h0; m_wdata = 32'h0; m_be = 4'h0;
        m_if_rdy = 1'b0; m_mem_rdy = 1'b0; m_err = 1'b0;
        m_if_rd = 32'h0; m_mem_rd = 32'h0;
    endtask

    task automatic m_step();
        bit          want_if, want_mem, finished, aborted;
        logic [31:0] result;
        want_if   = if_req && !m_if_rdy;
        want_mem  = mem_req && !m_mem_rdy;
        m_if_rdy  = 1'b0;
        m_mem_rdy = 1'b0;
        m_err     = 1'b0;
        finished  = 1'b0;
        aborted   = 1'b0;
        result    = 32'h0;
        if (m_owner != 0) begin
            if (bus_ack) begin
                finished = 1'b1;
                result   = bus_rdata;
            end else if (m_waited + 1 >= TO) begin
                finished = 1'b1;
                aborted  = 1'b1;
            end else begin
                m_waited++;
            end
            if (finished) begin
                if (m_owner == 1) begin m_if_rdy = 1'b1; m_if_rd = result; end
                else begin m_mem_rdy = 1'b1; m_mem_rd = result; end
                m_err   = aborted;
                m_owner = 0;
            end
        end else begin
            if (want_if && want_mem) m_owner = m_last_mem ? 1 : 2;
            else if (want_mem)       m_owner = 2;
            else if (want_if)        m_owner = 1;
            if (m_owner == 2) begin
                m_we = mem_we; m_addr = mem_addr; m_wdata = mem_wdata; m_be = mem_be;
                m_last_mem = 1'b1; m_waited = 0;
            end else if (m_owner == 1) begin
                m_we = 1'b0; m_addr = if_addr; m_wdata = 32'h0; m_be = 4'hF;
                m_last_mem = 1'b0; m_waited = 0;
            end
        end
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) m_reset();
            else     m_step();
        end
    end

    // ---------------- per-cycle compare against the model ----------------
    always @(negedge clk) begin
        chk("cyc_bus_req",     {31'b0, bus_req},     {31'b0, (m_owner != 0)});
        chk("cyc_if_ready",    {31'b0, if_ready},    {31'b0, m_if_rdy});
        chk("cyc_mem_ready",   {31'b0, mem_ready},   {31'b0, m_mem_rdy});
        chk("cyc_bus_err",     {31'b0, bus_err},     {31'b0, m_err});
        chk("cyc_if_rdata",    if_rdata,             m_if_rd);
        chk("cyc_mem_rdata",   mem_rdata,            m_mem_rd);
        chk("cyc_fetch_stall", {31'b0, fetch_stall}, {31'b0, if_req & ~m_if_rdy});
        chk("cyc_mem_stall",   {31'b0, mem_stall},   {31'b0, mem_req & ~m_mem_rdy});
        if (rst || m_owner != 0) begin
            chk("cyc_bus_we",    {31'b0, bus_we}, {31'b0, m_we});
            chk("cyc_bus_addr",  bus_addr,        m_addr);
            chk("cyc_bus_wdata", bus_wdata,       m_wdata);
            chk("cyc_bus_be",    {28'b0, bus_be}, {28'b0, m_be});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0; bus_ack = 1'b0;
        if_addr = 32'h0; mem_addr = 32'h0; mem_wdata = 32'h0; bus_rdata = 32'h0;
        mem_be = 4'h0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int seq[8];
        int prev;
        int ack_pct;
        int pcts[4];

        rst = 1'b0;
        clear_inputs();
        #1 rst = 1'b1;
        tick();
        tick();
        // Reset state
        chk("rst_bus_req",  {31'b0, bus_req},  32'h0);
        chk("rst_if_ready", {31'b0, if_ready}, 32'h0);
        chk("rst_bus_addr", bus_addr,          32'h0);
        rst = 1'b0;

        // Single fetch with minimum latency
        if_req = 1'b1; if_addr = 32'h0040_0000;
        tick();
        chk("fetch_bus_req",  {31'b0, bus_req}, 32'h1);
        chk("fetch_bus_addr", bus_addr,         32'h0040_0000);
        chk("fetch_bus_we",   {31'b0, bus_we},  32'h0);
        chk("fetch_bus_be",   {28'b0, bus_be},  32'hF);
        bus_ack = 1'b1; bus_rdata = 32'h2408_000A; if_req = 1'b0;
        tick();
        chk("fetch_ready",  {31'b0, if_ready}, 32'h1);
        chk("fetch_rdata",  if_rdata,          32'h2408_000A);
        chk("fetch_err",    {31'b0, bus_err},  32'h0);
        bus_ack = 1'b0;
        tick();
        chk("fetch_ready_pulse", {31'b0, if_ready}, 32'h0);
        chk("fetch_rdata_hold",  if_rdata,          32'h2408_000A);

        // Timeout with no ack at all
        if_req = 1'b1; if_addr = 32'h0040_0004;
        tick();
        if_req = 1'b0;
        for (int i = 1; i <= TO; i++) begin
            chk("to_bus_req_held", {31'b0, bus_req}, 32'h1);
            tick();
        end
        chk("to_bus_req_drop", {31'b0, bus_req},  32'h0);
        chk("to_ready",        {31'b0, if_ready}, 32'h1);
        chk("to_err",          {31'b0, bus_err},  32'h1);
        chk("to_rdata",        if_rdata,          32'h0);
        tick();
        chk("to_err_pulse",    {31'b0, bus_err},  32'h0);

        // Ack on the timeout boundary completes normally
        if_req = 1'b1; if_addr = 32'h0040_0008;
        tick();
        if_req = 1'b0;
        for (int i = 1; i < TO; i++) tick();
        chk("edge_bus_req", {31'b0, bus_req}, 32'h1);
        bus_ack = 1'b1; bus_rdata = 32'h0BAD_F00D;
        tick();
        bus_ack = 1'b0;
        chk("edge_ready", {31'b0, if_ready}, 32'h1);
        chk("edge_err",   {31'b0, bus_err},  32'h0);
        chk("edge_rdata", if_rdata,          32'h0BAD_F00D);

        // Contention after reset alternates MEM, IF, MEM, IF
        do_reset();
        if_req = 1'b1; if_addr = 32'h0040_0100;
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h1000_0000; mem_be = 4'hF;
        bus_ack = 1'b1; bus_rdata = 32'h5555_AAAA;
        seq = '{2, 0, 1, 0, 2, 0, 1, 0};
        prev = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("cont_bus_req", {31'b0, bus_req}, {31'b0, (seq[k] != 0)});
            if (seq[k] == 2) chk("cont_mem_addr", bus_addr, 32'h1000_0000);
            if (seq[k] == 1) chk("cont_if_addr",  bus_addr, 32'h0040_0100);
            if (seq[k] == 0) begin
                chk("cont_mem_ready", {31'b0, mem_ready}, {31'b0, (prev == 2)});
                chk("cont_if_ready",  {31'b0, if_ready},  {31'b0, (prev == 1)});
            end
            prev = seq[k];
        end
        if_req = 1'b0; mem_req = 1'b0;
        tick();
        bus_ack = 1'b0;

        // Store with three wait cycles while a fetch is pending
        do_reset();
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h1001_0004;
        mem_wdata = 32'hDEAD_BEEF; mem_be = 4'b0011;
        if_req = 1'b1; if_addr = 32'h0040_0200;
        tick();
        chk("st_bus_we",    {31'b0, bus_we}, 32'h1);
        chk("st_bus_addr",  bus_addr,        32'h1001_0004);
        chk("st_bus_wdata", bus_wdata,       32'hDEAD_BEEF);
        chk("st_bus_be",    {28'b0, bus_be}, 32'h3);
        for (int c = 1; c <= 4; c++) begin
            chk("st_fetch_stall", {31'b0, fetch_stall}, 32'h1);
            chk("st_no_ready",    {31'b0, mem_ready},   32'h0);
            if (c < 4) tick();
        end
        bus_ack = 1'b1; bus_rdata = 32'h0000_1234; mem_req = 1'b0;
        tick();
        chk("st_mem_ready",     {31'b0, mem_ready},   32'h1);
        chk("st_fetch_stall_5", {31'b0, fetch_stall}, 32'h1);
        chk("st_err",           {31'b0, bus_err},     32'h0);
        tick();
        chk("st_then_fetch", bus_addr, 32'h0040_0200);
        if_req = 1'b0;
        tick();
        chk("st_fetch_ready", {31'b0, if_ready}, 32'h1);
        bus_ack = 1'b0;

        // Reset in the second cycle of a data grant
        do_reset();
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h1002_0000;
        tick();
        chk("rg_bus_req", {31'b0, bus_req}, 32'h1);
        tick();
        rst = 1'b1;
        #1;
        chk("rg_bus_req_drop", {31'b0, bus_req},   32'h0);
        chk("rg_no_ready",     {31'b0, mem_ready}, 32'h0);
        if_req = 1'b1; if_addr = 32'h0040_0300;
        tick();
        chk("rg_no_ready_2", {31'b0, mem_ready}, 32'h0);
        rst = 1'b0;
        tick();
        chk("rg_mem_first", bus_addr, 32'h1002_0000);
        bus_ack = 1'b1; if_req = 1'b0; mem_req = 1'b0;
        tick();
        chk("rg_mem_ready", {31'b0, mem_ready}, 32'h1);
        tick();
        bus_ack = 1'b0;

        // Randomized traffic; the per-cycle compare does the checking
        pcts = '{0, 15, 60, 95};
        ack_pct = 60;
        for (int n = 0; n < 3000; n++) begin
            if (n % 200 == 0) ack_pct = pcts[$urandom_range(0, 3)];
            rst       = ($urandom_range(0, 499) == 0);
            if_req    = ($urandom_range(0, 99) < 60);
            mem_req   = ($urandom_range(0, 99) < 50);
            mem_we    = 1'($urandom_range(0, 1));
            if_addr   = $urandom;
            mem_addr  = $urandom;
            mem_wdata = $urandom;
            mem_be    = 4'($urandom_range(0, 15));
            bus_ack   = ($urandom_range(0, 99) < ack_pct);
            bus_rdata = $urandom;
            tick();
        end
        rst = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: bus_req cycles without bus_ack before abort (legal range 2..255).
REQ-002 SHALL have port clk  in  1  clock; all state updates on rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports if_req in 1, if_addr in 32: instruction fetch request and word address.
REQ-005 SHALL have ports if_rdata out 32, if_ready out 1: fetch data and one-cycle completion pulse.
REQ-006 SHALL have ports mem_req in 1, mem_we in 1, mem_addr in 32, mem_wdata in 32, mem_be in 4: data-stage request.
REQ-007 SHALL have ports mem_rdata out 32, mem_ready out 1: data-stage read data and one-cycle completion pulse.
REQ-008 SHALL have ports bus_req out 1, bus_we out 1, bus_addr out 32, bus_wdata out 32, bus_be out 4: shared single-port memory request.
REQ-009 SHALL have ports bus_rdata in 32, bus_ack in 1: memory response; ack valid only while bus_req=1.
REQ-010 SHALL have ports fetch_stall out 1, mem_stall out 1, bus_err out 1: pipeline stall lines and timeout pulse.

Function
REQ-011 SHALL implement FSM states IDLE, GRANT_IF, GRANT_MEM.
REQ-012 IDLE: only mem_req pending (unmasked) -> GRANT_MEM; only if_req -> GRANT_IF; neither -> IDLE.
REQ-013 IDLE, both pending: grant requester opposite to last_grant register; last_grant updates on every grant entry.
REQ-014 On grant entry, SHALL latch addr/we/wdata/be of winner into bus_* registers; IF grants drive bus_we=0, bus_be=4'hF, bus_wdata=0.
REQ-015 bus_req SHALL be 1 exactly while state is GRANT_IF or GRANT_MEM; bus_* stable for whole grant.
REQ-016 GRANT_x with bus_ack=1: capture bus_rdata into x_rdata, assert x_ready for the next cycle only, return IDLE.
REQ-017 Minimum latency: req sampled in IDLE cycle N, bus_req cycle N+1, ack in N+1 -> x_ready in N+2.
REQ-018 During the cycle x_ready=1 (state IDLE), requester x SHALL be masked from arbitration; other requester may be granted that cycle.
REQ-019 Deassertion of x_req during a grant SHALL be ignored; transaction completes normally.
REQ-020 8-bit wait counter SHALL clear on grant entry and increment each grant cycle without ack.
REQ-021 Counter = TIMEOUT-1 with no ack: abort -> IDLE, next cycle x_ready=1, bus_err=1, x_rdata=32'h0.
REQ-022 Ack in the same cycle as timeout boundary SHALL win: normal completion, no bus_err.
REQ-023 x_rdata SHALL hold its value until next completion of requester x.
REQ-024 fetch_stall = if_req & ~if_ready; mem_stall = mem_req & ~mem_ready (combinational).
REQ-025 bus_ack while in IDLE SHALL be ignored.

Reset
REQ-026 rst=1 SHALL immediately force state IDLE, bus_req=0, all bus_* =0, if_ready=mem_ready=bus_err=0, if_rdata=mem_rdata=0, counter=0, last_grant=IF.
REQ-027 rst mid-grant SHALL abandon the transaction with no ready pulse; first contention after reset grants MEM.

Verification
REQ-028 Single fetch: if_req=1, if_addr=0x00400000, ack one cycle after bus_req with rdata=0x2408000A -> bus_addr=0x00400000, bus_we=0, if_rdata=0x2408000A, if_ready pulse at N+2.
REQ-029 Contention after reset: if_req=mem_req=1 held -> grants MEM, IF, MEM, IF alternating; no grant to a requester in its ready cycle.
REQ-030 Store: mem_we=1, mem_addr=0x10010004, mem_wdata=0xDEADBEEF, mem_be=4'b0011, ack after 3 wait cycles -> bus fields match, mem_ready at cycle 5, fetch_stall=1 throughout for a pending fetch.
REQ-031 Timeout: TIMEOUT=16, never ack -> bus_req high 16 cycles, then if_ready=1, bus_err=1, if_rdata=0 for one cycle; ack on cycle 16 -> normal completion, bus_err=0.
REQ-032 Reset mid-grant: assert rst in cycle 2 of GRANT_MEM -> bus_req=0 same cycle, no mem_ready; after release both pending -> MEM granted first.
